execute_div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider in the Execute stage. It is fed by the

---
 rtl/execute_div_unit.sv | 156 +++++++++++++++
 tb/tb_execute_div_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the Execute stage.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero completes one cycle after accept.
module execute_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               flush_i,
    input  logic               hold_i,
    output logic               stall_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0]   divisor_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quot_reg;
    logic [WIDTH-1:0]   dividend_reg;
    logic [CW-1:0]      count_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               zero_reg;
    logic               ready_reg;
    logic [2*WIDTH-1:0] result_reg;

    logic               accept;
    logic               b_zero;
    logic               fast_zero;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               take;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quot_step;
    logic [WIDTH-1:0]   quot_final;
    logic [WIDTH-1:0]   rem_final;
    logic [2*WIDTH-1:0] busy_result;
    logic [2*WIDTH-1:0] zero_result;

    assign accept = (state_reg == IDLE) && start_i && !flush_i;
    assign b_zero = (b_i == '0);

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = b_zero;
`else
    assign fast_zero = 1'b0;
`endif

    // Magnitudes are taken only for DIV; DIVU operands pass through untouched.
    assign a_abs = (signed_i && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
    assign b_abs = (signed_i && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;

    // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial
    // difference and its top bit alone tells whether the subtraction borrowed.
    assign shifted   = {rem_reg, quot_reg[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor_reg};
    assign take      = !trial[WIDTH];
    assign rem_step  = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quot_step = {quot_reg[WIDTH-2:0], take};

    assign quot_final  = neg_q_reg ? ('0 - quot_step) : quot_step;
    assign rem_final   = neg_r_reg ? ('0 - rem_step) : rem_step;
    assign busy_result = zero_reg ? {dividend_reg, {WIDTH{1'b1}}} : {rem_final, quot_final};
    assign zero_result = {a_i, {WIDTH{1'b1}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o    = 1'b1;
                    state_next = fast_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (count_reg == LAST_COUNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!hold_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A flush discards whatever is in flight, including a same-cycle start.
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor_reg  <= '0;
            rem_reg      <= '0;
            quot_reg     <= '0;
            dividend_reg <= '0;
            count_reg    <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            ready_reg    <= 1'b0;
            result_reg   <= '0;
        end else begin
            ready_reg <= (state_next == DONE);
            if (accept) begin
                divisor_reg  <= b_abs;
                rem_reg      <= '0;
                quot_reg     <= a_abs;
                dividend_reg <= a_i;
                count_reg    <= '0;
                neg_q_reg    <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                neg_r_reg    <= signed_i && a_i[WIDTH-1];
                zero_reg     <= b_zero;
            end else if (state_reg == BUSY) begin
                rem_reg   <= rem_step;
                quot_reg  <= quot_step;
                count_reg <= count_reg + CW'(1);
            end
            // Result is written only on the transition into DONE and held otherwise.
            if (state_next == DONE && state_reg != DONE) begin
                result_reg <= (state_reg == IDLE) ? zero_result : busy_result;
            end
        end
    end

    assign ready_o  = ready_reg;
    assign result_o = result_reg;

endmodule

// File: tb/tb_execute_div_unit.sv
// Randomized self-checking bench for execute_div_unit against a cycle-level reference model.
// Honours DIV_ZERO_FAST_EN when it is defined for the build.
module tb_execute_div_unit;
    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int NLAT = W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          signed_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          flush_i;
    logic          hold_i;
    logic          stall_o;
    logic          ready_o;
    logic [2*W-1:0] result_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    execute_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .hold_i   (hold_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int lat_of(input logic [31:0] b);
        return (FAST && b == 32'd0) ? 1 : NLAT;
    endfunction

    // Transaction-level model: remaining busy cycles, done flag, last result.
    int           m_left   = 0;
    bit           m_done   = 1'b0;
    logic [63:0]  m_result = '0;
    logic [63:0]  m_pend   = '0;
    logic         exp_stall;

    always @(posedge clk) begin
        if (rst) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
        end else if (flush_i) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done   <= 1'b1;
                m_result <= m_pend;
            end
        end else if (m_done) begin
            if (!hold_i) m_done <= 1'b0;
        end else if (start_i) begin
            m_pend <= ref_div(a_i, b_i, signed_i);
            if (FAST && b_i == 32'd0) begin
                m_done   <= 1'b1;
                m_result <= ref_div(a_i, b_i, signed_i);
            end else begin
                m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_stall = (m_left > 0) || (!m_done && start_i && !flush_i);
            chk("cyc_stall", {63'd0, stall_o}, {63'd0, exp_stall});
            chk("cyc_ready", {63'd0, ready_o}, {63'd0, m_done});
            chk("cyc_result", result_o, m_result);
        end
    end

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int hold_n);
        int n, st, lat;
        bit seen;
        lat = lat_of(b);
        @(posedge clk); #1;
        a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
        n = 0; st = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
            else begin
                n++;
                if (stall_o) st++;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no ready_o after %0d cycles, required %0d", name, n, lat);
        end else begin
            chk({name, "_latency"}, 64'(n), 64'(lat));
            chk({name, "_stall_cycles"}, 64'(st), 64'(lat));
            chk({name, "_result"}, result_o, exp);
            if (hold_n > 0) begin
                hold_i = 1'b1;
                for (int k = 0; k < hold_n; k++) begin
                    @(negedge clk);
                    chk({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
                    chk({name, "_hold_result"}, result_o, exp);
                end
                hold_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        $display("div %s a=%h b=%h signed=%0d result=%h cycles=%0d hold=%0d", name, a, b, s, result_o, n, hold_n);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          sel;
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0;
        flush_i = 1'b0; hold_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", {63'd0, stall_o}, 64'd0);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0);
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 0);
        do_div("divu_5_0", 32'd5, 32'd0, 1'b0, {32'h0000_0005, 32'hFFFF_FFFF}, 0);
        do_div("div_m9_0", 32'hFFFF_FFF7, 32'd0, 1'b1, {32'hFFFF_FFF7, 32'hFFFF_FFFF}, 0);

        // Flush in BUSY cycle 10, then a fresh operation.
        @(posedge clk); #1;
        a_i = 32'd1000; b_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_stall", {63'd0, stall_o}, 64'd0);
        chk("flush_ready", {63'd0, ready_o}, 64'd0);
        chk("flush_result_kept", result_o, {32'hFFFF_FFF7, 32'hFFFF_FFFF});
        repeat (40) @(posedge clk);
        $display("flush at busy cycle 10 a=%h b=%h result=%h", 32'd1000, 32'd3, result_o);
        do_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0);

        do_div("divu_hold", 32'd100, 32'd9, 1'b0, {32'd1, 32'd11}, 3);

        // Start and flush together in IDLE.
        @(posedge clk); #1;
        a_i = 32'd50; b_i = 32'd5; start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        chk("sf_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("sf_idle_stall", {63'd0, stall_o}, 64'd0);
        chk("sf_ready", {63'd0, ready_o}, 64'd0);
        $display("start with flush a=%h b=%h stall=%0d ready=%0d", 32'd50, 32'd5, stall_o, ready_o);

        // Reset in BUSY cycle 20.
        @(posedge clk); #1;
        a_i = 32'd77; b_i = 32'd4; signed_i = 1'b0; start_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        $display("reset at busy cycle 20 result=%h", result_o);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rs  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = ~32'($urandom_range(0, 15));
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_div($sformatf("rand%0d", i), ra, rb, rs, ref_div(ra, rb, rs), $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
